rom_download_arbiter: RTL
=========================

// Module: rom_download_arbiter
// PURPOSE
// - Shares the core's program-ROM BRAM between the data_io download port and the CPU fetch port.
// - Sequences core reset around downloads: holds the core in reset during load, then for RESET_HOLD cycles after.
// - Sits between user_io/data_io and Tankb_fpga in the MiST top level.
// PARAMETERS
// AW          14   BRAM address width (ROM depth 2^AW bytes)
// DW           8   data width
// RESET_HOLD  16   cycles core_reset_n stays low after load end or reset request (>=1)
// DL_INDEX     0   ioctl index that targets this ROM; other indices are ignored
// PORTS
// clk_sys      in   1   system clock; all inputs synchronous to it
// RESET_n      in   1   asynchronous active-low reset
// rst_req      in   1   level user reset (status[0] | buttons[1])
// dl_active    in   1   ioctl_downl, download in progress
// dl_index     in   8   ioctl_index
// dl_wr        in   1   one-cycle write strobe
// dl_addr      in   24  download byte address
// dl_data      in   DW  download byte
// cpu_rd       in   1   CPU read request, one cycle
// cpu_addr     in   AW  CPU read address
// cpu_dout     out  DW  read data, registered
// cpu_valid    out  1   one-cycle pulse: cpu_dout valid
// core_reset_n out  1   active-low reset to game core
// mem_addr     out  AW  BRAM address, registered
// mem_din      out  DW  BRAM write data, registered
// mem_we       out  1   BRAM write enable, one cycle per accepted byte
// mem_dout     in   DW  BRAM read data, 1-cycle latency from mem_addr
// dl_overflow  out  1   sticky: a write with dl_addr >= 2^AW was dropped
// BEHAVIOUR
// - RESET_n=0 (async): state=HOLD, cnt=0, core_reset_n=0. All other outputs 0.
// - sel = dl_active & (dl_index==DL_INDEX).
// - States:
//   - RUN: CPU owns BRAM; core_reset_n=1.
//   - LOAD: download owns BRAM; core_reset_n=0.
//   - HOLD: nobody owns BRAM; core_reset_n=0; cnt counts up.
// - Transitions:
//   - RUN->LOAD on sel.
//   - RUN->HOLD (cnt=0) on rst_req.
//   - LOAD->HOLD (cnt=0) when sel=0 and no write is pending.
//   - HOLD->LOAD on sel.
//   - HOLD restarts at cnt=0 while rst_req=1.
//   - HOLD->RUN when cnt==RESET_HOLD-1 and rst_req=0.
//   - Priority: sel > rst_req > count.
// - core_reset_n is registered from the state; it rises one cycle after entering RUN.
// - CPU read (RUN only):
//   - cpu_rd in cycle n -> mem_addr=cpu_addr at n+1 -> cpu_dout=mem_dout, cpu_valid=1 at n+2.
//   - Fully pipelined: one read per cycle accepted.
//   - cpu_rd outside RUN is dropped; no cpu_valid is produced.
//   - A read in flight when RUN is left still completes its cpu_valid.
// - Download write (LOAD, or the same cycle sel enters LOAD):
//   - dl_wr in cycle n -> mem_addr=dl_addr[AW-1:0], mem_din=dl_data, mem_we=1 at n+1.
//   - Back-to-back strobes are written every cycle.
//   - dl_wr with dl_addr[23:AW]!=0: no mem_we; dl_overflow<=1.
//   - dl_overflow clears only on the next RUN->LOAD / HOLD->LOAD entry.
//   - dl_wr while sel=0 is ignored.
// - Last strobe coincident with the dl_active fall: the write completes first, then LOAD->HOLD.
// - mem_we is never asserted outside a download write; mem_we=1 implies core_reset_n=0.
// - cnt width is $clog2(RESET_HOLD)+1 and saturates; it never wraps.
// STRUCTURE
// - Shared package tankbatt_pkg:
//   - typedef enum logic [1:0] {ARB_RUN, ARB_LOAD, ARB_HOLD} arb_state_t
//   - localparam DL_ADDR_W = 24
// - No sub-module. Single always_ff for the FSM and counter, one for the two pipelines.
// TESTING
// - Reset release, rst_req=0, RESET_HOLD=16:
//   - core_reset_n stays 0 for 16 cycles, rises on cycle 17; mem_we never 1.
// - RUN, BRAM preloaded with 0xA5 at 0x0123, cpu_rd with cpu_addr=0x0123 at cycle n:
//   - cpu_valid=1, cpu_dout=0xA5 at n+2 only.
// - dl_active=1, dl_index=0, 4 consecutive dl_wr to addresses 0..3 with data 11,22,33,44:
//   - mem_we for 4 cycles; readback after HOLD gives 11,22,33,44.
// - Load 0x4000 with AW=14:
//   - No mem_we; dl_overflow=1 until the next download start.
// - dl_index=1 download:
//   - State stays RUN; no mem_we; core_reset_n remains 1.
// - sel rises in HOLD at cnt=8:
//   - LOAD entered; after dl_active falls, a full 16-cycle hold precedes RUN.
// - Last dl_wr on the cycle dl_active falls:
//   - The write is performed before LOAD->HOLD.

Source files
------------

// File: rtl/tankbatt_pkg.sv
// Shared types for the Tank Battalion MiST top level.
// Arbiter state encoding and download bus width.
package tankbatt_pkg;

  typedef enum logic [1:0] {
    ARB_RUN,
    ARB_LOAD,
    ARB_HOLD
  } arb_state_t;

  localparam int DL_ADDR_W = 24;

endpackage

// File: rtl/rom_download_arbiter.sv
// Shares the program-ROM BRAM between data_io downloads and CPU fetch,
// and keeps the game core in reset during and shortly after a load.
module rom_download_arbiter
  import tankbatt_pkg::*;
#(
  parameter int AW         = 14,
  parameter int DW         = 8,
  parameter int RESET_HOLD = 16,
  parameter int DL_INDEX   = 0
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 rst_req,
  input  logic                 dl_active,
  input  logic [7:0]           dl_index,
  input  logic                 dl_wr,
  input  logic [DL_ADDR_W-1:0] dl_addr,
  input  logic [DW-1:0]        dl_data,
  input  logic                 cpu_rd,
  input  logic [AW-1:0]        cpu_addr,
  output logic [DW-1:0]        cpu_dout,
  output logic                 cpu_valid,
  output logic                 core_reset_n,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_din,
  output logic                 mem_we,
  input  logic [DW-1:0]        mem_dout,
  output logic                 dl_overflow
);

  localparam int CW = $clog2(RESET_HOLD) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_HOLD - 1);
  localparam logic [7:0] DL_IDX = 8'(DL_INDEX);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rstn_q, rstn_d;

  logic          sel;
  logic          wr_acc;
  logic          wr_ok;
  logic          rd_acc;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic          rd1_q, rd1_d;
  logic          cpu_valid_q, cpu_valid_d;
  logic          ovf_q, ovf_d;

  assign sel = dl_active & (dl_index == DL_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_RUN: begin
        if (sel) begin
          state_d = ARB_LOAD;
        end else if (rst_req) begin
          state_d = ARB_HOLD;
          cnt_d   = '0;
        end
      end
      ARB_LOAD: begin
        // a write issued last cycle must land before leaving LOAD
        if (!sel && !mem_we_q) begin
          state_d = ARB_HOLD;
          cnt_d   = '0;
        end
      end
      ARB_HOLD: begin
        if (sel) begin
          state_d = ARB_LOAD;
        end else if (rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ARB_RUN;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ARB_HOLD;
        cnt_d   = '0;
      end
    endcase
    rstn_d = (state_q == ARB_RUN) && (state_d == ARB_RUN);
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ARB_HOLD;
      cnt_q   <= '0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
    end
  end

  always_comb begin
    wr_acc = dl_wr & sel;
    wr_ok  = wr_acc &
             (dl_addr[DL_ADDR_W-1:AW] == '0);
    rd_acc = cpu_rd & (state_q == ARB_RUN) & ~sel;

    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = wr_ok;
    rd1_d       = rd_acc;
    cpu_valid_d = rd1_q;
    ovf_d       = ovf_q;

    if (wr_ok) begin
      mem_addr_d = dl_addr[AW-1:0];
      mem_din_d  = dl_data;
    end else if (rd_acc) begin
      mem_addr_d = cpu_addr;
    end

    if (sel && state_q != ARB_LOAD) ovf_d = 1'b0;
    if (wr_acc && !wr_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      rd1_q       <= 1'b0;
      cpu_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      rd1_q       <= rd1_d;
      cpu_valid_q <= cpu_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // BRAM output register is the data stage of the read pipeline
  assign cpu_dout     = cpu_valid_q ? mem_dout : '0;
  assign cpu_valid    = cpu_valid_q;
  assign core_reset_n = rstn_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign mem_we       = mem_we_q;
  assign dl_overflow  = ovf_q;

endmodule
